// File: rtl/vent_pkg.sv
// rtl/vent_pkg.sv - state and fan speed encodings for the ventilation scheduler
package vent_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_COOL  = 3'd3;
  localparam logic [2:0] ST_REST  = 3'd4;

  localparam logic [1:0] SPD_OFF  = 2'd0;
  localparam logic [1:0] SPD_LOW  = 2'd1;
  localparam logic [1:0] SPD_NORM = 2'd2;
  localparam logic [1:0] SPD_FULL = 2'd3;

  function automatic logic [1:0] speed_of(input logic [2:0] st);
    case (st)
      ST_START: speed_of = SPD_FULL;
      ST_RUN:   speed_of = SPD_NORM;
      ST_COOL:  speed_of = SPD_LOW;
      default:  speed_of = SPD_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - synchronises the raw sensor and toggles demand after DEBOUNCE stable samples
module sensor_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic demand
);

  logic       s;
  logic [3:0] stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s      <= 1'b0;
      stable <= 4'd0;
      demand <= 1'b0;
    end else begin
      s <= sensor;
      // any sample agreeing with demand restarts the count, so glitches never accumulate
      if (s != demand) begin
        if (stable == 4'(DEBOUNCE - 1)) begin
          demand <= ~demand;
          stable <= 4'd0;
        end else begin
          stable <= stable + 4'd1;
        end
      end else begin
        stable <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/ventilation_scheduler.sv
// rtl/ventilation_scheduler.sv - fan sequencing FSM with spin-up, run limits, cool-down and rest
module ventilation_scheduler #(
  parameter int DEBOUNCE = 3,
  parameter int SPINUP   = 2,
  parameter int MIN_ON   = 4,
  parameter int MAX_ON   = 12,
  parameter int COOL     = 3,
  parameter int REST     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vintlation_sensor,
  input  logic       override_on,
  input  logic       override_off,
  output logic       fan_on,
  output logic [1:0] fan_speed,
  output logic [2:0] state_vintilation,
  output logic [3:0] counter,
  output logic       max_hit
);
  import vent_pkg::*;

  logic       demand;
  logic       eff;
  logic [2:0] state;
  logic [2:0] nxt;
  logic [3:0] timer;
  logic       max_go;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .sensor (vintlation_sensor),
    .demand (demand)
  );

  assign eff = (demand | override_on) & ~override_off;

  // timer counts from 0 on entry, so an interval of N cycles ends when it reads N-1
  always_comb begin
    nxt    = state;
    max_go = 1'b0;
    case (state)
      ST_IDLE:  if (eff) nxt = ST_START;
      ST_START: if (timer >= 4'(SPINUP - 1)) nxt = ST_RUN;
      ST_RUN: begin
        if (timer >= 4'(MAX_ON - 1)) begin
          nxt    = ST_REST;
          max_go = 1'b1;
        end else if (!eff && timer >= 4'(MIN_ON - 1)) begin
          nxt = ST_COOL;
        end
      end
      ST_COOL: begin
        if (eff) nxt = ST_RUN;
        else if (timer >= 4'(COOL - 1)) nxt = ST_IDLE;
      end
      ST_REST:  if (timer >= 4'(REST - 1)) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (override_off) begin
      nxt    = ST_IDLE;
      max_go = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= 4'd0;
      counter <= 4'd0;
      max_hit <= 1'b0;
    end else begin
      state   <= nxt;
      max_hit <= max_go;
      if (nxt != state) timer <= 4'd0;
      else if (timer != 4'hf) timer <= timer + 4'd1;
      if (state == ST_START && nxt == ST_RUN && counter != 4'hf)
        counter <= counter + 4'd1;
    end
  end

  assign fan_speed         = speed_of(state);
  assign fan_on            = (fan_speed != SPD_OFF);
  assign state_vintilation = state;

endmodule

// File: doc/ventilation_scheduler.md
# ventilation_scheduler

Sequences the room ventilation fan from the raw ventilation sensor. Debounces the sensor and enforces spin-up, minimum-run, maximum-run, cool-down and rest intervals. Drives fan enable and speed, and keeps a saturating count of completed run cycles for the status display. Sits between the ventilation sensor pin and the fan driver in the smart-room top level.

## Interface
Parameters (all values 1..15; MIN_ON <= MAX_ON):
- DEBOUNCE, 3: consecutive equal sensor samples needed to change demand
- SPINUP, 2: cycles at full speed after start
- MIN_ON, 4: minimum cycles in RUN before demand loss is honoured
- MAX_ON, 12: cycles in RUN after which the fan is forced off
- COOL, 3: low-speed cycles after demand loss
- REST, 5: forced-off cycles after a MAX_ON expiry

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- vintlation_sensor  in  1  raw ventilation request, asynchronous to clk
- override_on  in  1  synchronous; forces demand = 1
- override_off  in  1  synchronous; forces fan off, highest priority
- fan_on  out  1  fan enable
- fan_speed  out  2  0 off, 1 low, 2 normal, 3 full
- state_vintilation  out  3  current state encoding
- counter  out  4  completed RUN entries, saturating at 15
- max_hit  out  1  one-cycle pulse on a MAX_ON expiry

## Operation
- Sensor path: one sync flop `s`. A stable counter increments while `s != demand` and clears when `s == demand`. When it reaches DEBOUNCE, `demand` toggles and the counter clears.
- Effective demand: `eff = (demand | override_on) & ~override_off`.
- 4-bit `timer` clears on every state change, increments each cycle, and saturates at 15.
- IDLE (0): outputs off. If `eff`, go to START.
- START (1): speed 3. After SPINUP cycles, go to RUN and increment `counter` (saturating).
- RUN (2): speed 2.
  - After MAX_ON cycles: go to REST and pulse `max_hit`. This takes precedence over demand loss.
  - Else if `!eff` and at least MIN_ON cycles have elapsed: go to COOL.
- COOL (3): speed 1.
  - If `eff`: go to RUN. The timer clears; `counter` is not incremented.
  - After COOL cycles: go to IDLE.
- REST (4): outputs off, demand ignored. After REST cycles, go to IDLE.
- `override_off` moves any state to IDLE on the next edge, overriding every rule above. REST is abandoned.
- `fan_on = (fan_speed != 0)`.
- `fan_speed` and `state_vintilation` are Moore outputs decoded from the state register.
- Unused encodings 5-7 go to IDLE.

## Timing
- Reset values: state IDLE, demand 0, `s` 0, timer 0, `counter` 0, `fan_on` 0, `fan_speed` 0, `max_hit` 0.
- Reset asserted mid-run clears everything immediately; the run in progress is not counted.
- Sensor latency: sensor high before edge E0 and held.
  - `s` = 1 at E0.
  - `demand` = 1 at E0+DEBOUNCE.
  - START and fan speed 3 at E0+DEBOUNCE+1.
- A glitch shorter than DEBOUNCE samples never changes `demand`.
- `override_on` / `override_off` act combinationally on `eff`: state changes on the first edge at which they are sampled.
- When both overrides are asserted, off wins.
- RUN with `eff` high lasts exactly MAX_ON cycles. With `eff` low from entry, RUN lasts exactly MIN_ON cycles.
- `counter` updates on the same edge as the START->RUN transition. It stays at 15 once saturated.

## Structure
- Package `vent_pkg`:
  - state constants IDLE..REST (3-bit)
  - speed constants OFF/LOW/NORM/FULL (2-bit)
- Sub-module `sensor_debounce`: sync flop plus stable counter, parameter DEBOUNCE, output `demand`.
- The scheduler FSM and timer live in the top module.

## Test plan
- Sensor high held from reset release, defaults: START after the 4th edge, RUN 2 cycles later with `counter` = 1, REST after 12 RUN cycles with `max_hit` pulsed once, then IDLE 5 cycles later.
- Sensor pulse high for 2 cycles only: `demand` stays 0 and `fan_on` stays 0 throughout.
- Demand drops 1 cycle into RUN: RUN lasts 4 cycles, COOL with speed 1 lasts 3, then IDLE; `counter` = 1.
- Demand returns during COOL: back to RUN with speed 2; `counter` unchanged; timer restarts so MAX_ON counts from re-entry.
- `override_off` pulsed in RUN while `override_on` = 1: IDLE on the next edge with `fan_speed` 0; a subsequent `override_on` alone starts START within one edge.
- 16 complete short runs: `counter` saturates at 15. `rst` asserted mid-RUN: all outputs 0 immediately, without waiting for a clock edge.
